// File: rtl/debug_pkg.sv
// Shared state encoding, command mode codes and command-length helper for debug_scanner.
package debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_LIVE  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MODE_LIVE     = 2'b00,
        MODE_SNAPSHOT = 2'b01,
        MODE_SCAN     = 2'b10,
        MODE_RSVD     = 2'b11
    } mode_e;

    localparam int unsigned MODE_W = 32'd2;

    // A command is the mode field followed by the channel address, MSB first.
    function automatic int unsigned cmd_len(input int unsigned addr_w);
        return MODE_W + addr_w;
    endfunction

    // Even-parity bit for a channel word zero-extended to 32 bits.
    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/debug_chsel.sv
// Channel selector: slices the addressed channel out of the probe bus;
// addresses with no matching channel yield an all-zero word.
module debug_chsel
    import debug_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int CH_W   = 16,
    parameter int ADDR_W = 4
) (
    input  logic [NUM_CH*CH_W-1:0] probe_i,
    input  logic [ADDR_W-1:0]      addr_i,
    output logic [CH_W-1:0]        word_o
);

    // AND-OR mux: out-of-range addresses match no channel and fall through to zero.
    always_comb begin
        word_o = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            word_o = word_o | ({CH_W{addr_i == ADDR_W'(n)}} & probe_i[n*CH_W +: CH_W]);
        end
    end

endmodule

// File: rtl/debug_scanner.sv
// Serial debug scanner: command decoder, live/snapshot/scan FSM and output shifter.
// Optional DEBUG_PARITY_EN appends an even-parity bit to every snapshot/scan frame.
module debug_scanner
    import debug_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int CH_W   = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   debug_clk,
    input  logic                   reset,
    input  logic [NUM_CH*CH_W-1:0] probe,
    input  logic                   debug_in,
    output logic                   debug_out,
    output logic                   debug_sync
);

    localparam int CMD_LEN = int'(cmd_len(ADDR_W));
`ifdef DEBUG_PARITY_EN
    localparam int FRAME_LEN = CH_W + 1;
`else
    localparam int FRAME_LEN = CH_W;
`endif
    localparam int CNT_MAX = (CMD_LEN > FRAME_LEN) ? CMD_LEN : FRAME_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CH_W-1:0]     shreg_q, shreg_d;
    logic                out_q, out_d;
    logic                sync_q, sync_d;
`ifdef DEBUG_PARITY_EN
    logic                par_q, par_d;
`endif

    logic [CMD_LEN-1:0]  cmd_shift_s;
    logic [ADDR_W-1:0]   next_addr_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [CH_W-1:0]     ch_word_s;
    logic                capture_s;

    // Mode and address form one shift register while a command is clocked in.
    assign cmd_shift_s = {mode_q[0], addr_q, debug_in};
    assign next_addr_s = (addr_q >= ADDR_W'(NUM_CH - 1)) ? '0 : addr_q + ADDR_W'(1);

    // Address seen by the selector on this edge: freshly shifted command or next scan channel.
    always_comb begin
        sel_addr_s = addr_q;
        case (state_q)
            ST_CMD:  sel_addr_s = cmd_shift_s[ADDR_W-1:0];
            ST_GAP:  sel_addr_s = next_addr_s;
            default: sel_addr_s = addr_q;
        endcase
    end

    debug_chsel #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .ADDR_W (ADDR_W)
    ) u_chsel (
        .probe_i (probe),
        .addr_i  (sel_addr_s),
        .word_o  (ch_word_s)
    );

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        out_d     = 1'b0;
        sync_d    = 1'b0;
        capture_s = 1'b0;
`ifdef DEBUG_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (debug_in) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                mode_d = mode_e'(cmd_shift_s[CMD_LEN-1 -: MODE_W]);
                addr_d = cmd_shift_s[ADDR_W-1:0];
                if (cnt_q == CNT_W'(CMD_LEN - 1)) begin
                    case (mode_d)
                        MODE_LIVE: begin
                            state_d = ST_LIVE;
                            out_d   = ch_word_s[0];
                        end
                        MODE_SNAPSHOT, MODE_SCAN: capture_s = 1'b1;
                        default:                  state_d   = ST_IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LIVE: begin
                out_d = ch_word_s[0];
                if (debug_in) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_LIVE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q < CNT_W'(CH_W)) begin
                    out_d   = shreg_q[CH_W-1];
                    shreg_d = shreg_q << 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
`ifdef DEBUG_PARITY_EN
                end else if (cnt_q == CNT_W'(CH_W)) begin
                    out_d = par_q;
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end else begin
                    state_d = (mode_q == MODE_SCAN) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (debug_in) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end else begin
                    addr_d    = next_addr_s;
                    capture_s = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Capture drives the channel MSB on this same edge; the rest trails in SHIFT.
        if (capture_s) begin
            state_d = ST_SHIFT;
            cnt_d   = CNT_W'(1);
            shreg_d = ch_word_s << 1'b1;
            out_d   = ch_word_s[CH_W-1];
            sync_d  = 1'b1;
`ifdef DEBUG_PARITY_EN
            par_d   = even_parity(32'(ch_word_s));
`endif
        end else begin
            sync_d = 1'b0;
        end
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge debug_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_LIVE;
            addr_q  <= '0;
            cnt_q   <= '0;
            shreg_q <= '0;
            out_q   <= 1'b0;
            sync_q  <= 1'b0;
`ifdef DEBUG_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            out_q   <= out_d;
            sync_q  <= sync_d;
`ifdef DEBUG_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign debug_out  = out_q;
    assign debug_sync = sync_q;

endmodule

// File: doc/debug_scanner.md
DEBUG_SCANNER -- requirements
Module: debug_scanner

Interface
REQ-001 SHALL have parameter NUM_CH, default 16, number of probe channels (2..64).
REQ-002 SHALL have parameter CH_W, default 16, bits per channel (1..32).
REQ-003 SHALL have parameter ADDR_W, default 4, channel-address width; it SHALL be at least clog2(NUM_CH).
REQ-004 SHALL have port debug_clk, input, 1, serial debug clock.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-006 SHALL have port probe, input, NUM_CH*CH_W, channel n occupies bits [n*CH_W +: CH_W].
REQ-007 SHALL have port debug_in, input, 1, serial command input, sampled on posedge debug_clk.
REQ-008 SHALL have port debug_out, output, 1, registered serial data.
REQ-009 SHALL have port debug_sync, output, 1, registered, high only during the first data bit of each frame.

Function
REQ-010 SHALL implement the states IDLE, CMD, LIVE, SHIFT and GAP.
REQ-011 In IDLE, LIVE or GAP, debug_in=1 SHALL be taken as a start bit; the next state SHALL be CMD.
REQ-012 CMD SHALL shift in 2 mode bits, then ADDR_W address bits, all MSB first, one per edge.
REQ-013 Mode 00 (LIVE): every edge SHALL register debug_out <= bit 0 of the addressed channel, with 1-cycle latency; debug_sync SHALL stay 0.
REQ-014 Mode 01 (SNAPSHOT): on the edge that samples the last address bit, the channel SHALL be captured and its MSB SHALL be driven with debug_sync=1.
REQ-015 In SNAPSHOT, the remaining CH_W-1 bits SHALL follow on consecutive edges; the FSM SHALL then return to IDLE with debug_out=0.
REQ-016 Mode 10 (SCAN) SHALL behave as SNAPSHOT, but each frame SHALL be followed by one GAP cycle (debug_out=0).
REQ-017 In SCAN, the next frame SHALL capture address+1, wrapping from NUM_CH-1 to 0, and scanning SHALL continue until a start bit is accepted in GAP.
REQ-018 Mode 11 is reserved and SHALL return to IDLE with no output.
REQ-019 An address >= NUM_CH SHALL produce an all-zero channel word; in SCAN such an address SHALL wrap to 0 for the next frame.
REQ-020 Probe changes after the capture edge SHALL NOT affect the frame in progress.
REQ-021 debug_in SHALL be ignored in SHIFT.

Reset
REQ-022 Reset SHALL force state=IDLE, debug_out=0, debug_sync=0, mode=00, address=0 and shift register=0, immediately and including mid-frame.
REQ-023 After reset deasserts, the first accepted start bit SHALL be sampled at the first debug_clk edge.

Configuration
REQ-024 When DEBUG_PARITY_EN is defined, one even-parity bit over the captured word SHALL follow the last data bit of each SNAPSHOT/SCAN frame, with debug_sync=0.
REQ-025 When DEBUG_PARITY_EN is undefined, a frame SHALL be exactly CH_W bits, and no parity logic SHALL be generated.

Structure
REQ-026 The state encoding, the mode codes (LIVE, SNAPSHOT, SCAN, RSVD) and the command length constant SHALL reside in the shared package debug_pkg.
REQ-027 The channel selection (probe slice plus out-of-range zeroing) SHALL be a sub-module debug_chsel; the FSM and shift register SHALL remain in debug_scanner.

Verification (NUM_CH=16, CH_W=16, ADDR_W=4)
REQ-028 SNAPSHOT: command 1,01,0011 with channel 3=16'hA5C3 -> debug_out 1010010111000011 over 16 cycles, debug_sync on the first bit only, parity 0 if enabled, then IDLE.
REQ-029 LIVE: command 1,00,0111 with probe[112] toggling every cycle -> debug_out follows it one cycle later, debug_sync=0.
REQ-030 SCAN: command 1,10,1110 -> frames for channels 14, 15, 0, 1, each separated by one 0 GAP cycle; a start bit in GAP -> CMD.
REQ-031 NUM_CH=12, SNAPSHOT address 13 -> 16 zero bits, debug_sync=1 on the first.
REQ-032 Reset asserted at bit 5 of a frame -> debug_out=0 and debug_sync=0 immediately; a new command after release works normally.
REQ-033 Channel 3 changed to 16'hFFFF during SHIFT -> the captured 16'hA5C3 frame SHALL be unchanged.
